btn_load_pulse: RTL and testbench

Debounces a raw switch or button and turns each press into a single-`clk` load strobe, with optional hold-to-repeat. It sits directly upstream of a 4-bit register's `load` input, between the board switch and the register. It uses the existing 1 ms divided clock as a sampling timebase, so one press loads the register exactly once, and holding the switch steps the counter at a fixed rate.

---
 rtl/btn_load_pulse_if.sv | 25 ++
 rtl/btn_load_pulse.sv | 160 ++++++++++++++++
 tb/tb_btn_load_pulse.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/btn_load_pulse_if.sv
// Button/strobe bundle between the board-side stimulus (switch and 1 ms
// timebase) and the debouncer that drives a register's load input.
interface btn_load_pulse_if;
  logic clk_1ms;
  logic btn_in;
  logic load_out;
  logic btn_state;
  logic repeat_active;

  modport master (
    output clk_1ms,
    output btn_in,
    input  load_out,
    input  btn_state,
    input  repeat_active
  );

  modport slave (
    input  clk_1ms,
    input  btn_in,
    output load_out,
    output btn_state,
    output repeat_active
  );
endinterface

// File: rtl/btn_load_pulse.sv
// Switch debouncer with single-clock load strobe and hold-to-repeat.
// The 1 ms divided clock is sampled as data; its synchronised rising edge
// is the timebase for both the debounce and the repeat counters.
module btn_load_pulse #(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input logic             clk,
  input logic             rst,
  btn_load_pulse_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } fsmState_t;

  localparam logic [9:0] C_DB        = 10'(DEBOUNCE_MS);
  localparam logic [9:0] C_DELAY     = 10'(REPEAT_DELAY_MS);
  localparam logic [9:0] C_RATE      = 10'(REPEAT_RATE_MS);
  localparam bit         C_REPEAT_EN = (REPEAT_DELAY_MS != 0);

  logic [1:0] r_btnSync;
  logic [1:0] r_msSync;
  logic       r_msPrev;
  logic [9:0] r_dbCnt;
  logic       r_btnState;
  fsmState_t  r_state;
  logic [9:0] r_rpCnt;
  logic       r_loadOut;

  logic       w_btnS;
  logic       w_msS;
  logic       w_tick;
  logic       w_dbHit;
  logic       w_pressAcc;
  logic       w_releaseAcc;
  logic       w_rpHit;
  fsmState_t  w_nextState;
  logic [9:0] w_rpCntNext;
  logic       w_loadNext;

  assign w_btnS = r_btnSync[1];
  assign w_msS  = r_msSync[1];
  // r_msPrev clears on reset, so a timebase already high at reset release
  // produces a tick on its first synchronised sample.
  assign w_tick = w_msS & ~r_msPrev;

  assign w_dbHit      = ((r_dbCnt + 10'd1) == C_DB);
  assign w_pressAcc   = w_tick & w_btnS & ~r_btnState & w_dbHit;
  assign w_releaseAcc = w_tick & ~w_btnS & r_btnState & w_dbHit;
  assign w_rpHit      = ((r_rpCnt + 10'd1) == ((r_state == HOLD) ? C_DELAY : C_RATE));

  // Two-flop synchronisers for the raw switch and the 1 ms timebase, plus the edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btnSync <= 2'b00;
      r_msSync  <= 2'b00;
      r_msPrev  <= 1'b0;
    end else begin
      r_btnSync <= {r_btnSync[0], bus.btn_in};
      r_msSync  <= {r_msSync[0], bus.clk_1ms};
      r_msPrev  <= w_msS;
    end
  end

  // Debounce: a changed level must persist for DEBOUNCE_MS consecutive ticks before it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbCnt    <= 10'd0;
      r_btnState <= 1'b0;
    end else if (w_tick) begin
      if (w_btnS != r_btnState) begin
        if (w_dbHit) begin
          r_btnState <= ~r_btnState;
          r_dbCnt    <= 10'd0;
        end else begin
          r_dbCnt <= r_dbCnt + 10'd1;
        end
      end else begin
        r_dbCnt <= 10'd0;
      end
    end
  end

  // FSM state register, with the repeat counter and the registered load strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rpCnt   <= 10'd0;
      r_loadOut <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_rpCnt   <= w_rpCntNext;
      r_loadOut <= w_loadNext;
    end
  end

  // Next-state logic: an accepted release always returns to IDLE, ahead of any due repeat.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_pressAcc) w_nextState = HOLD;
      end
      HOLD: begin
        if (w_releaseAcc)                          w_nextState = IDLE;
        else if (w_tick && C_REPEAT_EN && w_rpHit) w_nextState = REPEAT;
      end
      REPEAT: begin
        if (w_releaseAcc) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output logic: strobe on press and on each repeat interval; the counter stays frozen in HOLD when repeat is disabled.
  always_comb begin
    w_loadNext  = 1'b0;
    w_rpCntNext = r_rpCnt;
    case (r_state)
      IDLE: begin
        w_rpCntNext = 10'd0;
        if (w_pressAcc) w_loadNext = 1'b1;
      end
      HOLD: begin
        if (w_releaseAcc) begin
          w_rpCntNext = 10'd0;
        end else if (w_tick && C_REPEAT_EN) begin
          if (w_rpHit) begin
            w_loadNext  = 1'b1;
            w_rpCntNext = 10'd0;
          end else begin
            w_rpCntNext = r_rpCnt + 10'd1;
          end
        end
      end
      REPEAT: begin
        if (w_releaseAcc) begin
          w_rpCntNext = 10'd0;
        end else if (w_tick) begin
          if (w_rpHit) begin
            w_loadNext  = 1'b1;
            w_rpCntNext = 10'd0;
          end else begin
            w_rpCntNext = r_rpCnt + 10'd1;
          end
        end
      end
      default: w_rpCntNext = 10'd0;
    endcase
  end

  assign bus.load_out      = r_loadOut;
  assign bus.btn_state     = r_btnState;
  assign bus.repeat_active = (r_state == REPEAT);

endmodule

// File: tb/tb_btn_load_pulse.sv
// Bench for btn_load_pulse: expected strobe tick numbers are queued as each
// press is driven and popped by a monitor whenever a strobe appears.
module tb_btn_load_pulse;

  logic clk;
  logic rst;
  logic clk1ms;
  logic btnA;
  logic btn0;
  int   tickNum;
  int   testsRun;
  int   failCount;
  int   qA[$];
  int   q0[$];
  int   expA;
  int   exp0;
  logic prevA;
  logic prev0;

  btn_load_pulse_if busA ();
  btn_load_pulse_if bus0 ();

  assign busA.clk_1ms = clk1ms;
  assign busA.btn_in  = btnA;
  assign bus0.clk_1ms = clk1ms;
  assign bus0.btn_in  = btn0;

  btn_load_pulse #(.DEBOUNCE_MS(3), .REPEAT_DELAY_MS(4), .REPEAT_RATE_MS(2)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  btn_load_pulse #(.DEBOUNCE_MS(3), .REPEAT_DELAY_MS(0), .REPEAT_RATE_MS(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // System clock: 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1 ms timebase stand-in: 5 clk high, 5 clk low, changed on falling clk edges.
  initial begin
    clk1ms = 1'b0;
    forever begin
      repeat (5) @(negedge clk);
      clk1ms = ~clk1ms;
    end
  end

  // Numbers each timebase rising edge so strobes can be located in ticks.
  initial tickNum = 0;
  always @(posedge clk1ms) tickNum++;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tick %0d)", tag, observed, expected, tickNum);
    end
  endtask

  task automatic waitFalls(input int n);
    repeat (n) @(negedge clk1ms);
  endtask

  task automatic applyStimulus(input bit useDut0, input logic level, input int holdFalls);
    if (useDut0) btn0 = level;
    else         btnA = level;
    waitFalls(holdFalls);
  endtask

  // Scoreboard monitor for the repeating instance.
  always @(posedge clk) begin
    #1;
    if (busA.load_out) begin
      expA = (qA.size() > 0) ? qA.pop_front() : -1;
      checkOutput("pulseTickA", tickNum, expA);
      checkOutput("pulseWidthA", int'(prevA), 0);
    end
    prevA = busA.load_out;
  end

  // Scoreboard monitor for the repeat-disabled instance.
  always @(posedge clk) begin
    #1;
    if (bus0.load_out) begin
      exp0 = (q0.size() > 0) ? q0.pop_front() : -1;
      checkOutput("pulseTick0", tickNum, exp0);
      checkOutput("pulseWidth0", int'(prev0), 0);
    end
    prev0 = bus0.load_out;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int a;
    testsRun  = 0;
    failCount = 0;
    prevA     = 1'b0;
    prev0     = 1'b0;
    btnA      = 1'b0;
    btn0      = 1'b0;
    rst       = 1'b1;
    #12;
    checkOutput("rstLoad",   int'(busA.load_out), 0);
    checkOutput("rstState",  int'(busA.btn_state), 0);
    checkOutput("rstRepeat", int'(busA.repeat_active), 0);
    #13;
    rst = 1'b0;
    waitFalls(2);

    // Clean press: accepted on the 3rd tick, released before any repeat is due.
    k = tickNum;
    qA.push_back(k + 3);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("preAccept", int'(busA.btn_state), 0);
    waitFalls(1);
    checkOutput("accepted", int'(busA.btn_state), 1);
    checkOutput("noRepeatYet", int'(busA.repeat_active), 0);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("releasePending", int'(busA.btn_state), 1);
    waitFalls(1);
    checkOutput("released", int'(busA.btn_state), 0);
    waitFalls(2);

    // Bounce: toggles every 15 clk never hold long enough to be accepted.
    for (int i = 0; i < 7; i++) begin
      btnA = ~btnA;
      repeat (15) @(negedge clk);
    end
    btnA = 1'b0;
    waitFalls(5);
    checkOutput("bounceState", int'(busA.btn_state), 0);

    // Hold/repeat: strobes at offsets 0,4,6,...,14; release lands on a due repeat and wins.
    k = tickNum;
    a = k + 3;
    qA.push_back(a);
    for (int off = 4; off <= 14; off += 2) qA.push_back(a + off);
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("holdRepeat3", int'(busA.repeat_active), 0);
    waitFalls(1);
    checkOutput("holdRepeat4", int'(busA.repeat_active), 1);
    waitFalls(9);
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("windowRepeat", int'(busA.repeat_active), 1);
    checkOutput("windowState", int'(busA.btn_state), 1);
    waitFalls(1);
    checkOutput("relRepeat", int'(busA.repeat_active), 0);
    checkOutput("relState", int'(busA.btn_state), 0);
    waitFalls(2);

    // Release accepted on the tick the first repeat would be due: no strobe.
    k = tickNum;
    a = k + 3;
    qA.push_back(a);
    applyStimulus(1'b0, 1'b1, 4);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("rvrRepeat", int'(busA.repeat_active), 0);
    checkOutput("rvrState", int'(busA.btn_state), 0);
    waitFalls(2);

    // Reset while repeating with the button still held, then re-debounce.
    k = tickNum;
    a = k + 3;
    qA.push_back(a);
    qA.push_back(a + 4);
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("preRstRepeat", int'(busA.repeat_active), 1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midRstLoad",   int'(busA.load_out), 0);
    checkOutput("midRstState",  int'(busA.btn_state), 0);
    checkOutput("midRstRepeat", int'(busA.repeat_active), 0);
    #19;
    rst = 1'b0;
    qA.push_back(a + 8);
    waitFalls(2);
    checkOutput("reDebounce", int'(busA.btn_state), 0);
    waitFalls(1);
    checkOutput("reAccepted", int'(busA.btn_state), 1);
    checkOutput("reRepeat", int'(busA.repeat_active), 0);
    applyStimulus(1'b0, 1'b0, 5);

    // Repeat disabled: one strobe for a long hold, never enters REPEAT.
    k = tickNum;
    q0.push_back(k + 3);
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("disState", int'(bus0.btn_state), 1);
    waitFalls(20);
    checkOutput("disRepeat", int'(bus0.repeat_active), 0);
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("disReleased", int'(bus0.btn_state), 0);
    waitFalls(2);

    checkOutput("pendingA", qA.size(), 0);
    checkOutput("pending0", q0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
